// File: rtl/liteic_rr_arbiter.sv
// rtl/liteic_rr_arbiter.sv - round-robin arbiter granting one liteic slave region to NUM_MASTERS requesters
// Optional forced release after TIMEOUT_CYCLES busy cycles when LITEIC_ARB_TIMEOUT_EN is defined.
module liteic_rr_arbiter #(
    parameter int unsigned NUM_MASTERS    = 4,
    parameter int unsigned IDX_WIDTH      = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [NUM_MASTERS-1:0] req_i,
    input  logic                   txn_done_i,
    output logic [NUM_MASTERS-1:0] grant_o,
    output logic [IDX_WIDTH-1:0]   grant_idx_o,
    output logic                   busy_o,
    output logic                   timeout_o
);

    if (NUM_MASTERS < 1 || NUM_MASTERS > 16 || TIMEOUT_CYCLES < 2) begin : g_bad_param
        $error("liteic_rr_arbiter: illegal NUM_MASTERS or TIMEOUT_CYCLES");
    end

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t                 state_q;
    logic [NUM_MASTERS-1:0] grant_q;
    logic [IDX_WIDTH-1:0]   grant_idx_q;
    logic                   busy_q;
    logic [IDX_WIDTH-1:0]   rr_ptr_q;
    logic [IDX_WIDTH-1:0]   rr_ptr_d;
    logic [NUM_MASTERS-1:0] rot;
    logic                   pick_valid;
    logic [IDX_WIDTH-1:0]   pick_idx;

    // Rotate requests so bit 0 is the highest-priority master, then take the lowest set bit.
    always_comb begin
        rot        = NUM_MASTERS'({req_i, req_i} >> rr_ptr_q);
        pick_valid = 1'b0;
        pick_idx   = '0;
        for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
            if (rot[i]) begin
                pick_valid = 1'b1;
                pick_idx   = IDX_WIDTH'((int'(rr_ptr_q) + i) % int'(NUM_MASTERS));
            end
        end
    end

    // Explicit wrap keeps non-power-of-2 configurations inside 0..NUM_MASTERS-1.
    assign rr_ptr_d = (grant_idx_q == IDX_WIDTH'(NUM_MASTERS - 1)) ? '0 : grant_idx_q + 1'b1;

`ifdef LITEIC_ARB_TIMEOUT_EN
    localparam int unsigned TIMER_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [TIMER_W-1:0] TIMER_MAX = TIMER_W'(TIMEOUT_CYCLES - 1);

    logic [TIMER_W-1:0] timer_q;
    logic               timeout_q;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            grant_q     <= '0;
            grant_idx_q <= '0;
            busy_q      <= 1'b0;
            rr_ptr_q    <= '0;
`ifdef LITEIC_ARB_TIMEOUT_EN
            timer_q     <= '0;
            timeout_q   <= 1'b0;
`endif
        end else begin
`ifdef LITEIC_ARB_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
            case (state_q)
                S_IDLE: begin
                    if (pick_valid) begin
                        grant_q     <= NUM_MASTERS'(1) << pick_idx;
                        grant_idx_q <= pick_idx;
                        busy_q      <= 1'b1;
                        state_q     <= S_BUSY;
`ifdef LITEIC_ARB_TIMEOUT_EN
                        timer_q     <= '0;
`endif
                    end
                end
                S_BUSY: begin
                    if (txn_done_i) begin
                        grant_q  <= '0;
                        busy_q   <= 1'b0;
                        rr_ptr_q <= rr_ptr_d;
                        state_q  <= S_IDLE;
                    end
`ifdef LITEIC_ARB_TIMEOUT_EN
                    else if (timer_q == TIMER_MAX) begin
                        grant_q   <= '0;
                        busy_q    <= 1'b0;
                        rr_ptr_q  <= rr_ptr_d;
                        state_q   <= S_IDLE;
                        timeout_q <= 1'b1;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
`endif
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign grant_o     = grant_q;
    assign grant_idx_o = grant_idx_q;
    assign busy_o      = busy_q;
`ifdef LITEIC_ARB_TIMEOUT_EN
    assign timeout_o   = timeout_q;
`else
    assign timeout_o   = 1'b0;
`endif

endmodule

// File: tb/tb_liteic_rr_arbiter.sv
// tb/tb_liteic_rr_arbiter.sv - self-checking bench for liteic_rr_arbiter with a transaction-level model
module tb_liteic_rr_arbiter;
    localparam int N  = 4;
    localparam int TO = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] req = '0;
    logic         done = 1'b0;
    logic [N-1:0] grant_o;
    logic [1:0]   grant_idx_o;
    logic         busy_o;
    logic         timeout_o;

    int total = 0;
    int bad   = 0;

    // model: who holds the slave, whose turn is next, how long the holder has held it
    int           m_busy = 0;
    int           m_owner = 0;
    int           m_next = 0;
    int           m_held = 0;
    int           m_to = 0;
    logic [N-1:0] m_grant = '0;

    liteic_rr_arbiter #(.NUM_MASTERS(N), .TIMEOUT_CYCLES(TO)) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .txn_done_i(done),
        .grant_o(grant_o), .grant_idx_o(grant_idx_o), .busy_o(busy_o), .timeout_o(timeout_o)
    );

    always #5 clk = ~clk;

    task automatic model_edge();
        int timeout_en;
        timeout_en = 0;
`ifdef LITEIC_ARB_TIMEOUT_EN
        timeout_en = 1;
`endif
        m_to = 0;
        if (rst) begin
            m_busy = 0; m_next = 0; m_owner = 0; m_held = 0;
        end else if (m_busy == 0) begin
            for (int off = N - 1; off >= 0; off--)
                if (req[(m_next + off) % N]) begin
                    m_owner = (m_next + off) % N;
                    m_busy  = 1;
                    m_held  = 0;
                end
        end else begin
            m_held = m_held + 1;
            if (done) begin
                m_busy = 0; m_next = (m_owner + 1) % N;
            end else if (timeout_en == 1 && m_held == TO) begin
                m_busy = 0; m_next = (m_owner + 1) % N; m_to = 1;
            end
        end
        m_grant = (m_busy == 1) ? (N'(1) << m_owner) : '0;
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; done = 1'b0; req = '0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 4'b1111; done = 1'b0;
        for (int c = 0; c < 2; c++) begin
            tick();
            total++;
            if (grant_o !== 4'b0000 || busy_o !== 1'b0) begin
                bad++; $display("FAIL reset_hold cyc=%0d got grant=%b busy=%b exp grant=0000 busy=0", c, grant_o, busy_o);
            end
        end
        rst = 1'b0;
        tick();
        total++;
        if (grant_o !== 4'b0001 || grant_idx_o !== 2'd0 || busy_o !== 1'b1) begin
            bad++; $display("FAIL reset_first_grant got grant=%b idx=%0d busy=%b exp 0001/0/1", grant_o, grant_idx_o, busy_o);
        end
        done = 1'b1; tick(); done = 1'b0;
    endtask

    task automatic test_rotation();
        do_reset();
        req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            tick();
            total++;
            if (grant_o !== (4'b0001 << (g % 4)) || grant_o !== m_grant || grant_idx_o !== 2'(g % 4)) begin
                bad++; $display("FAIL rotation_grant g=%0d got=%b idx=%0d exp=%b", g, grant_o, grant_idx_o, 4'b0001 << (g % 4));
            end
            tick(); tick();
            done = 1'b1;
            tick();
            done = 1'b0;
            total++;
            if (grant_o !== 4'b0000 || busy_o !== 1'b0) begin
                bad++; $display("FAIL rotation_gap g=%0d got grant=%b busy=%b exp 0000/0", g, grant_o, busy_o);
            end
        end
    endtask

    task automatic test_skip_wrap();
        req = 4'b0100;
        tick();
        done = 1'b1; tick(); done = 1'b0;
        req = 4'b0011;
        tick();
        total++;
        if (grant_o !== 4'b0001 || grant_idx_o !== 2'd0 || grant_o !== m_grant) begin
            bad++; $display("FAIL skip_wrap got=%b idx=%0d exp=0001 idx=0", grant_o, grant_idx_o);
        end
        done = 1'b1; tick(); done = 1'b0;
    endtask

    task automatic test_hold();
        req = 4'b0100;
        tick();
        req = 4'b1000;
        for (int c = 0; c < 4; c++) begin
            tick();
            total++;
            if (grant_o !== 4'b0100 || grant_idx_o !== 2'd2) begin
                bad++; $display("FAIL hold_stable cyc=%0d got=%b idx=%0d exp=0100 idx=2", c, grant_o, grant_idx_o);
            end
        end
        done = 1'b1; tick(); done = 1'b0;
        total++;
        if (grant_o !== 4'b0000) begin
            bad++; $display("FAIL hold_release got=%b exp=0000", grant_o);
        end
        tick();
        total++;
        if (grant_o !== 4'b1000 || grant_o !== m_grant) begin
            bad++; $display("FAIL hold_next got=%b exp=1000", grant_o);
        end
    endtask

    task automatic test_reset_mid_busy();
        rst = 1'b1; tick(); rst = 1'b0;
        total++;
        if (grant_o !== 4'b0000 || busy_o !== 1'b0) begin
            bad++; $display("FAIL midbusy_reset got grant=%b busy=%b exp 0000/0", grant_o, busy_o);
        end
        req = 4'b1111;
        tick();
        total++;
        if (grant_o !== 4'b0001) begin
            bad++; $display("FAIL midbusy_next got=%b exp=0001", grant_o);
        end
        done = 1'b1; tick(); done = 1'b0;
    endtask

    task automatic test_timeout();
        do_reset();
        req = 4'b1111;
`ifdef LITEIC_ARB_TIMEOUT_EN
        for (int c = 0; c < TO; c++) begin
            tick();
            total++;
            if (grant_o !== 4'b0001 || timeout_o !== 1'b0) begin
                bad++; $display("FAIL timeout_hold cyc=%0d got grant=%b to=%b exp 0001/0", c, grant_o, timeout_o);
            end
        end
        tick();
        total++;
        if (timeout_o !== 1'b1 || grant_o !== 4'b0000 || busy_o !== 1'b0) begin
            bad++; $display("FAIL timeout_fire got to=%b grant=%b busy=%b exp 1/0000/0", timeout_o, grant_o, busy_o);
        end
        tick();
        total++;
        if (timeout_o !== 1'b0 || grant_o !== 4'b0010) begin
            bad++; $display("FAIL timeout_next got to=%b grant=%b exp 0/0010", timeout_o, grant_o);
        end
        for (int c = 1; c < TO; c++) tick();
        done = 1'b1; tick(); done = 1'b0;
        total++;
        if (timeout_o !== 1'b0 || grant_o !== 4'b0000) begin
            bad++; $display("FAIL timeout_done_wins got to=%b grant=%b exp 0/0000", timeout_o, grant_o);
        end
`else
        for (int c = 0; c < 3 * TO; c++) begin
            tick();
            total++;
            if (grant_o !== 4'b0001 || timeout_o !== 1'b0) begin
                bad++; $display("FAIL no_timeout_hold cyc=%0d got grant=%b to=%b exp 0001/0", c, grant_o, timeout_o);
            end
        end
        done = 1'b1; tick(); done = 1'b0;
`endif
    endtask

    task automatic test_random();
        int wait_cnt [N];
        do_reset();
        for (int k = 0; k < N; k++) wait_cnt[k] = 0;
        for (int c = 0; c < 600; c++) begin
            req  = N'($urandom);
            if ($urandom_range(0, 3) == 0) req = 4'b1111;
            done = ($urandom_range(0, 3) == 0);
            rst  = ($urandom_range(0, 99) == 0);
            tick();
            total++;
            if (grant_o !== m_grant || busy_o !== 1'(m_busy) || timeout_o !== 1'(m_to) ||
                (m_busy == 1 && grant_idx_o !== 2'(m_owner))) begin
                bad++; $display("FAIL random cyc=%0d got grant=%b idx=%0d busy=%b to=%b exp grant=%b idx=%0d busy=%0d to=%0d",
                                c, grant_o, grant_idx_o, busy_o, timeout_o, m_grant, m_owner, m_busy, m_to);
            end
        end
        rst = 1'b0; done = 1'b0;
    endtask

    initial begin
        test_reset();
        test_rotation();
        test_skip_wrap();
        test_hold();
        test_reset_mid_busy();
        test_timeout();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
